// File: rtl/cs_resolver_if.sv
// Handshake bundle for cs_resolver: carry-save pair in, resolved (WIDTH+1)-bit sum out.
// The slave modport is the resolver's view; master is the producer/consumer side.
interface cs_resolver_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_result;

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/cs_resolver.sv
// Carry-save to binary resolver, CHUNK bits per cycle; out_valid rises WIDTH/CHUNK cycles after accept.
// Holds the result under indefinite out_ready backpressure; CS_RESOLVER_PIPE_EN lets DONE accept the next pair.
module cs_resolver #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic        clk,
  input logic        rst_n,
  cs_resolver_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             run_c;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic [WIDTH:0]   result_q;
  logic             valid_q;

  logic             in_ready_c;
  logic             accept;
  logic             retire;
  logic [CHUNK-1:0] sum_chunk;
  logic [CHUNK-1:0] carry_chunk;
  logic [CHUNK:0]   chunk_add;

  always_comb begin
    sum_chunk   = sum_q[idx*CHUNK +: CHUNK];
    carry_chunk = carry_q[idx*CHUNK +: CHUNK];
    chunk_add   = {1'b0, sum_chunk} + {1'b0, carry_chunk} + {{CHUNK{1'b0}}, run_c};
  end

`ifdef CS_RESOLVER_PIPE_EN
  // Retiring and accepting on the same edge removes the IDLE bubble.
  assign in_ready_c = (state == IDLE) || ((state == DONE) && bus.out_ready);
`else
  assign in_ready_c = (state == IDLE);
`endif

  assign accept         = bus.in_valid && in_ready_c;
  assign retire         = valid_q && bus.out_ready;
  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      run_c    <= 1'b0;
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sum_q    <= bus.in_sum;
            carry_q  <= bus.in_carry;
            result_q <= '0;
            run_c    <= 1'b0;
            idx      <= '0;
            state    <= ADD;
          end
        end
        ADD: begin
          result_q[idx*CHUNK +: CHUNK] <= chunk_add[CHUNK-1:0];
          run_c <= chunk_add[CHUNK];
          if (idx == LAST) begin
            result_q[WIDTH] <= chunk_add[CHUNK];
            valid_q         <= 1'b1;
            state           <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (retire) begin
            valid_q <= 1'b0;
            if (accept) begin
              sum_q    <= bus.in_sum;
              carry_q  <= bus.in_carry;
              result_q <= '0;
              run_c    <= 1'b0;
              idx      <= '0;
              state    <= ADD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cs_resolver.sv
// Self-checking bench for cs_resolver (WIDTH=16, CHUNK=4): vector table, corner sequences, random traffic.
// Inputs change on the falling edge; outputs are sampled 1 time unit after it.
module tb_cs_resolver;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;
`ifdef CS_RESOLVER_PIPE_EN
  localparam int EXP_GAP = N;
`else
  localparam int EXP_GAP = N + 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  cs_resolver_if #(.WIDTH(WIDTH)) bus ();

  cs_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    int               hold;
    logic [WIDTH:0]   exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
    return {1'b0, s} + {1'b0, c};
  endfunction

  // One full transaction; garbage is offered on the input during ADD to prove it is ignored.
  task automatic run_op(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                        input int hold, input logic [WIDTH:0] exp);
    int guard;
    int acc;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_sum    = s;
    bus.in_carry  = c;
    bus.out_ready = (hold == 0);
    #1;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("accept_wait", 32'(guard < 20), 32'd1);
    acc = cyc + 1;
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      bus.in_valid = (k < N) ? k[0] : 1'b0;
      bus.in_sum   = 16'($urandom);
      bus.in_carry = 16'($urandom);
      #1;
      check("add_in_ready", 32'(bus.in_ready), 32'd0);
      check("add_out_valid", 32'(bus.out_valid), 32'd0);
    end
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (!bus.out_valid && guard < 20);
    check("latency", 32'(cyc - acc), 32'(N));
    check("result", 32'(bus.out_result), 32'(exp));
    if (hold > 0) begin
      for (int h = 1; h < hold; h++) begin
        @(negedge clk);
        #1;
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_result", 32'(bus.out_result), 32'(exp));
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    check("retire_drop", 32'(bus.out_valid), 32'd0);
    check("result_kept", 32'(bus.out_result), 32'(exp));
  endtask

  initial begin
    logic [WIDTH:0] q[$];
    logic           held;
    logic [WIDTH:0] held_val;
    int             acc_edges[$];
    int             nacc;
    int             nret;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;

    vecs[0] = '{16'hFFFF, 16'h0001, 0,  17'h10000};
    vecs[1] = '{16'h1234, 16'h4321, 0,  17'h05555};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 10, 17'h1FFFE};
    vecs[3] = '{16'h0000, 16'h0000, 0,  17'h00000};
    vecs[4] = '{16'h8000, 16'h8000, 2,  17'h10000};
    vecs[5] = '{16'hAAAA, 16'h5555, 0,  17'h0FFFF};
    vecs[6] = '{16'h00F0, 16'h0010, 0,  17'h00100};
    vecs[7] = '{16'h0FFF, 16'h0001, 1,  17'h01000};

    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_carry  = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_result", 32'(bus.out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) run_op(vecs[i].s, vecs[i].c, vecs[i].hold, vecs[i].exp);

    // Abort in the second ADD cycle; the partial sum must vanish.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_sum    = 16'hFFFF;
    bus.in_carry  = 16'h0003;
    bus.out_ready = 1'b1;
    #1;
    check("abort_accept", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_out_result", 32'(bus.out_result), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 0, 17'h00002);

    // Back-to-back with in_valid held; gap is whole cycles strictly between accept edges.
    nacc = 0;
    nret = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && nret < 2; k++) begin
      @(negedge clk);
      bus.in_valid = (nacc < 2);
      bus.in_sum   = (nacc == 0) ? 16'h0F0F : 16'h7FFF;
      bus.in_carry = (nacc == 0) ? 16'h00F1 : 16'h0001;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        check((nret == 0) ? "b2b_res0" : "b2b_res1", 32'(bus.out_result),
              (nret == 0) ? 32'h01000 : 32'h08000);
        nret++;
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_edges.push_back(cyc + 1);
        nacc++;
      end
    end
    bus.in_valid = 1'b0;
    check("b2b_results", 32'(nret), 32'd2);
    if (acc_edges.size() == 2)
      check("b2b_gap", 32'(acc_edges[1] - acc_edges[0] - 1), 32'(EXP_GAP));
    else
      check("b2b_accepts", 32'(acc_edges.size()), 32'd2);

    // Random traffic against a queue of exact sums.
    held     = 1'b0;
    held_val = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 4))
        0:       begin s = 16'hFFFF; c = 16'hFFFF; end
        1:       begin s = 16'h0000; c = 16'h0000; end
        default: begin s = 16'($urandom); c = 16'($urandom); end
      endcase
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_sum    = s;
      bus.in_carry  = c;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (held) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_result", 32'(bus.out_result), 32'(held_val));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("spurious_out", 32'(q.size()), 32'd1);
        else check("rand_result", 32'(bus.out_result), 32'(q.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model_sum(s, c));
      held     = bus.out_valid && !bus.out_ready;
      held_val = bus.out_result;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) check("drain_result", 32'(bus.out_result), 32'(q.pop_front()));
    end
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
